// File: rtl/if_fetch_unit.sv
// RV32I fetch: holds PC, one outstanding imem read, presents {instr, pc, pc+4} to IF/ID; response shown next cycle
// (same cycle with IF_RESP_BYPASS_EN); stall_in holds the one-entry buffer, redirects squash to the bubble word.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0060,
  parameter logic [31:0] BUBBLE   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_read,
  output logic [31:0] imem_address,
  input  logic [31:0] imem_rdata,
  input  logic        imem_resp,
  input  logic        stall_in,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        direct_jump,
  input  logic [31:0] jump_target,
  output logic        load_out,
  output logic [31:0] instruction_out,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4_out
);

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    FULL    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc_q, pc_nxt;
  logic [31:0] pc_pend, pend_nxt;
  logic [31:0] buf_instr, buf_pc;
  logic        buf_ld;
  logic        redir;
  logic [31:0] target;
  logic        byp_fire;

  // EX redirects win over ID jumps; a stalled ID jump is not yet real.
  assign redir  = redirect_valid | (direct_jump & ~stall_in);
  assign target = redirect_valid ? redirect_pc : jump_target;

`ifdef IF_RESP_BYPASS_EN
  assign byp_fire = (state == FETCH) & imem_resp & ~redir & ~stall_in;
`else
  assign byp_fire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH: begin
        if (imem_resp && !redir) state_nxt = byp_fire ? FETCH : FULL;
        else if (!imem_resp && redir) state_nxt = DISCARD;
      end
      FULL:    if (redir || !stall_in) state_nxt = FETCH;
      DISCARD: if (imem_resp) state_nxt = FETCH;
      default: state_nxt = FETCH;
    endcase
  end

  always_comb begin
    pc_nxt   = pc_q;
    pend_nxt = pc_pend;
    buf_ld   = 1'b0;
    case (state)
      FETCH: begin
        if (imem_resp && redir) begin
          pc_nxt = target;
        end else if (redir) begin
          pend_nxt = target;
        end else if (imem_resp) begin
          buf_ld = 1'b1;
          pc_nxt = pc_q + 32'd4;
        end
      end
      FULL: if (redir) pc_nxt = target;
      DISCARD: begin
        // The address on the bus stays stale until the dropped response returns.
        if (redir) pend_nxt = target;
        if (imem_resp) pc_nxt = redir ? target : pc_pend;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      pc_pend   <= '0;
      buf_instr <= '0;
      buf_pc    <= '0;
    end else begin
      pc_q    <= pc_nxt;
      pc_pend <= pend_nxt;
      if (buf_ld) begin
        buf_instr <= imem_rdata;
        buf_pc    <= pc_q;
      end
    end
  end

  always_comb begin
    imem_read       = ~rst & (state != FULL);
    imem_address    = rst ? '0 : pc_q;
    load_out        = ~rst & ~stall_in;
    instruction_out = BUBBLE;
    pc_out          = '0;
    pc_plus4_out    = '0;
    if (rst) begin
      instruction_out = '0;
    end else if (!redir) begin
      if (state == FULL) begin
        instruction_out = buf_instr;
        pc_out          = buf_pc;
        pc_plus4_out    = buf_pc + 32'd4;
      end else if (byp_fire) begin
        instruction_out = imem_rdata;
        pc_out          = pc_q;
        pc_plus4_out    = pc_q + 32'd4;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Fetch-unit bench: directed scenarios then random stall/redirect/latency traffic against a transaction-level model.
module tb_if_fetch_unit;

`ifdef IF_RESP_BYPASS_EN
  localparam int LAT = 0;
`else
  localparam int LAT = 1;
`endif
  localparam logic [31:0] RST_PC = 32'h0000_0060;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_read;
  logic [31:0] imem_address;
  logic [31:0] imem_rdata = '0;
  logic        imem_resp = 1'b0;
  logic        stall_in = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        direct_jump = 1'b0;
  logic [31:0] jump_target = '0;
  logic        load_out;
  logic [31:0] instruction_out, pc_out, pc_plus4_out;

  if_fetch_unit dut (
    .clk(clk), .rst(rst),
    .imem_read(imem_read), .imem_address(imem_address),
    .imem_rdata(imem_rdata), .imem_resp(imem_resp),
    .stall_in(stall_in),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .direct_jump(direct_jump), .jump_target(jump_target),
    .load_out(load_out), .instruction_out(instruction_out),
    .pc_out(pc_out), .pc_plus4_out(pc_plus4_out)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, n_deliv = 0, n_issue = 0;
  int mem_lat = 1, cnt = 0;
  bit busy = 0, cur_red = 1, cur_done = 1;
  logic [31:0] cur_addr = '0, exp_addr = RST_PC;
  bit s_issue, s_deliv, s_resp, s_read;
  logic [31:0] s_addr, s_instr, s_pc, s_p4;

  function automatic logic [31:0] memword(input logic [31:0] a);
    if (a == 32'h60) return 32'h0000_0013;
    if (a == 32'h64) return 32'h0010_0093;
    return a ^ 32'h5A5A_0003;
  endfunction

  function automatic logic [31:0] rnd_tgt();
    if ($urandom_range(0, 15) == 0) return 32'hFFFF_FFF8 + 32'($urandom_range(0, 1)) * 32'd4;
    return 32'($urandom_range(0, 255)) << 2;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, play the memory, then check outputs against the model.
  task automatic step(input bit r, input bit st, input bit rv, input logic [31:0] rpc,
                      input bit dj, input logic [31:0] jt);
    bit redir;
    logic [31:0] tgt;
    @(negedge clk);
    rst = r; stall_in = st; redirect_valid = rv; redirect_pc = rpc;
    direct_jump = dj; jump_target = jt;
    s_issue = 0; s_deliv = 0; s_resp = 0;
    if (busy) begin
      imem_resp  = (cnt == 0);
      imem_rdata = memword(cur_addr);
    end else begin
      imem_resp  = 1'b0;
      imem_rdata = $urandom;
    end
    #1;
    s_read = imem_read; s_addr = imem_address; s_instr = instruction_out;
    s_pc = pc_out; s_p4 = pc_plus4_out; s_resp = imem_resp;
    if (r) begin
      chk("rst_read", 32'(imem_read), 0);
      chk("rst_load", 32'(load_out), 0);
      chk("rst_instr", instruction_out, 0);
      chk("rst_pc", pc_out, 0);
      chk("rst_pc4", pc_plus4_out, 0);
      busy = 0; cur_red = 1; exp_addr = RST_PC;
      imem_resp = 1'b0;
      return;
    end
    if (imem_read && !busy) begin
      s_issue = 1; n_issue++;
      if (!cur_red) chk("prev_delivered", 32'(cur_done), 1);
      chk("req_addr", imem_address, exp_addr);
      cur_addr = imem_address; exp_addr = imem_address + 32'd4;
      busy = 1; cnt = mem_lat; cur_red = 0; cur_done = 0;
    end else if (busy) begin
      chk("read_held", 32'(imem_read), 1);
      chk("addr_stable", imem_address, cur_addr);
    end
    chk("load_out", 32'(load_out), 32'(!st));
    redir = rv | (dj & ~st);
    tgt   = rv ? rpc : jt;
    if (redir) begin
      chk("squash_instr", instruction_out, 0);
      chk("squash_pc", pc_out, 0);
      chk("squash_pc4", pc_plus4_out, 0);
      cur_red = 1; exp_addr = tgt;
    end else if (load_out && instruction_out != 0) begin
      s_deliv = 1; n_deliv++;
      chk("not_squashed", 32'(cur_red), 0);
      chk("no_dup", 32'(cur_done), 0);
      chk("deliv_pc", pc_out, cur_addr);
      chk("deliv_instr", instruction_out, memword(cur_addr));
      chk("deliv_pc4", pc_plus4_out, cur_addr + 32'd4);
      cur_done = 1;
    end else if (instruction_out == 0) begin
      chk("bubble_pc", pc_out, 0);
    end
    if (s_resp) busy = 0;
    else if (busy) cnt--;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic wait_ev(input bit want_deliv);
    int n = 0;
    do begin idle(); n++; end while (!(want_deliv ? s_deliv : s_issue) && n < 30);
    chk(want_deliv ? "wait_deliv" : "wait_issue", 32'(want_deliv ? s_deliv : s_issue), 1);
  endtask

  initial begin
    bit r, st, rv, dj;
    repeat (3) step(1, 0, 0, 0, 0, 0);

    mem_lat = 1;
    idle();
    chk("first_issue", 32'(s_issue), 1);
    chk("first_addr", s_addr, 32'h60);
    wait_ev(1);
    chk("i0_pc", s_pc, 32'h60);
    chk("i0_pc4", s_p4, 32'h64);
    wait_ev(0);
    chk("i1_addr", s_addr, 32'h64);

    step(0, 1, 0, 0, 0, 0);
    chk("i1_resp", 32'(s_resp), 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 0, 0, 0);
      chk("hold_read", 32'(s_read), 0);
      chk("hold_instr", s_instr, 32'h0010_0093);
      chk("hold_pc", s_pc, 32'h64);
    end
    mem_lat = 3;
    idle();
    chk("release_deliv", 32'(s_deliv), 1);
    chk("release_instr", s_instr, 32'h0010_0093);
    chk("release_pc4", s_p4, 32'h68);

    idle();
    chk("i2_issue", 32'(s_issue), 1);
    chk("i2_addr", s_addr, 32'h68);
    mem_lat = 2;
    idle();
    step(0, 0, 1, 32'h200, 0, 0);
    chk("disc_addr", s_addr, 32'h68);
    idle();
    chk("disc_resp", 32'(s_resp), 1);
    chk("disc_dropped", 32'(s_deliv), 0);
    idle();
    chk("redir_issue", 32'(s_issue), 1);
    chk("redir_addr", s_addr, 32'h200);

    step(0, 0, 1, 32'h300, 1, 32'h80);
    wait_ev(0);
    chk("prio_addr", s_addr, 32'h300);
    step(0, 1, 0, 0, 1, 32'h80);
    wait_ev(1);
    chk("jump_ignored_pc", s_pc, 32'h300);
    wait_ev(0);
    chk("seq_addr", s_addr, 32'h304);

    step(0, 0, 1, 32'hFFFF_FFFC, 0, 0);
    wait_ev(0);
    chk("top_addr", s_addr, 32'hFFFF_FFFC);
    mem_lat = 1;
    wait_ev(1);
    chk("top_pc", s_pc, 32'hFFFF_FFFC);
    chk("top_pc4", s_p4, 32'h0);
    wait_ev(0);
    chk("wrap_addr", s_addr, 32'h0);
    idle();
    chk("lat_resp", 32'(s_resp), 1);
    chk("lat_same_cycle", 32'(s_deliv), 32'(LAT == 0));
    idle();
    chk("lat_next_cycle", 32'(s_deliv), 32'(LAT == 1));

    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 399) == 0);
      st = ($urandom_range(0, 9) < 3);
      rv = ($urandom_range(0, 11) == 0);
      dj = ($urandom_range(0, 9) == 0);
      mem_lat = $urandom_range(1, 3);
      step(r, st, rv, rnd_tgt(), dj, rnd_tgt());
      if (r) step(1, 0, 0, 0, 0, 0);
    end
    chk("deliveries", 32'(n_deliv >= 200), 1);
    chk("issues", 32'(n_issue >= 300), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
